mem_write_queue: RTL and testbench

MEM_WRITE_QUEUE -- requirements
Module: mem_write_queue

---
 rtl/Purple_Jade_pkg.sv | 16 +
 rtl/mwq_age_match.sv | 49 ++++
 rtl/mem_write_queue.sv | 129 ++++++++++++
 tb/tb_mem_write_queue.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/Purple_Jade_pkg.sv
// Purple_Jade_pkg
// Shared definitions for the Purple_Jade memory subsystem.
//   WORD_SIZE_P         : address / data width used across the core
//   MWQ_ENTRY_DEFAULT   : default depth of the memory write queue
//   mwq_entry_t         : one queued committed store, {address, data}
package Purple_Jade_pkg;

  localparam int WORD_SIZE_P       = 32;
  localparam int MWQ_ENTRY_DEFAULT = 4;

  typedef struct packed {
    logic [WORD_SIZE_P-1:0] address;
    logic [WORD_SIZE_P-1:0] data;
  } mwq_entry_t;

endpackage

// File: rtl/mwq_age_match.sv
// mwq_age_match
// Youngest-match priority select for the memory write queue.
// The physical match vector is rotated so that index 0 is the oldest entry
// (the head); only the first 'count' rotated positions are occupied, and the
// highest occupied matching position is the youngest store.
// Ports:
//   match : per physical entry, address equals the lookup address
//   head  : physical index of the oldest entry
//   count : number of occupied entries
//   hit   : some occupied entry matches
//   sel   : physical index of the youngest matching entry
module mwq_age_match #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  match,
  input  logic [PW-1:0] head,
  input  logic [PW:0]   count,
  output logic          hit,
  output logic [PW-1:0] sel
);

  logic [N-1:0]  rotated;
  logic [PW-1:0] idx;

  // Rotate by head: rotated[k] is the entry k positions younger than the head.
  // N is a power of two, so the PW-bit sum wraps around the ring for free.
  always_comb begin
    rotated = '0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      idx        = head + PW'(k);
      rotated[k] = match[idx];
    end
  end

  // Later (younger) occupied matches override earlier ones.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int k = 0; k < N; k++) begin
      if (rotated[k] && ((PW+1)'(k) < count)) begin
        hit = 1'b1;
        sel = head + PW'(k);
      end
    end
  end

endmodule

// File: rtl/mem_write_queue.sv
// mem_write_queue
// Circular FIFO of architecturally committed stores waiting to be written to
// data memory. Entries are never flushed on misprediction.
// Optional feature: define MWQ_LD_FWD_EN to enable store-to-load forwarding.
// Ports:
//   clk_i, reset_n_i            : clock, asynchronous active-low reset
//   sb_mem_v_i/addr_i/data_i    : store-buffer commit push
//   mwq_full_o, mwq_empty_o     : occupancy status (registered count only)
//   mem_v_o/addr_o/data_o       : write request to data memory (head entry)
//   mem_ready_i                 : memory accepts the write this cycle
//   ld_addr_i                   : load lookup address
//   ld_hit_o, ld_data_o         : youngest matching pending store
//   mwq_overflow_o              : sticky, set by a push while full
// MWQ_ENTRY must be a power of two, at least 2.
module mem_write_queue #(
  parameter int MWQ_ENTRY   = Purple_Jade_pkg::MWQ_ENTRY_DEFAULT,
  parameter int WORD_SIZE_P = Purple_Jade_pkg::WORD_SIZE_P
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   sb_mem_v_i,
  input  logic [WORD_SIZE_P-1:0] sb_mem_addr_i,
  input  logic [WORD_SIZE_P-1:0] sb_mem_data_i,
  output logic                   mwq_full_o,
  output logic                   mwq_empty_o,
  output logic                   mem_v_o,
  output logic [WORD_SIZE_P-1:0] mem_addr_o,
  output logic [WORD_SIZE_P-1:0] mem_data_o,
  input  logic                   mem_ready_i,
  input  logic [WORD_SIZE_P-1:0] ld_addr_i,
  output logic                   ld_hit_o,
  output logic [WORD_SIZE_P-1:0] ld_data_o,
  output logic                   mwq_overflow_o
);

  localparam int PW = $clog2(MWQ_ENTRY);
  localparam int CW = PW + 1;

  typedef Purple_Jade_pkg::mwq_entry_t entry_t;

  entry_t        entries [MWQ_ENTRY];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic          overflow;
  logic          push;
  logic          pop;

  // Status is decoded from the registered count so the ROB sees no
  // combinational path from the memory handshake or the push strobe.
  assign mwq_full_o     = (count == CW'(MWQ_ENTRY));
  assign mwq_empty_o    = (count == '0);
  assign mwq_overflow_o = overflow;

  // A push in the same cycle as a pop while full is still rejected, because
  // full is the registered value.
  assign push = sb_mem_v_i & ~mwq_full_o;
  assign pop  = mem_v_o & mem_ready_i;

  // The head entry only changes on a pop, which keeps the request stable
  // while the memory stalls. Gating with empty forces zeros after reset.
  assign mem_v_o    = ~mwq_empty_o;
  assign mem_addr_o = mwq_empty_o ? '0 : entries[head].address;
  assign mem_data_o = mwq_empty_o ? '0 : entries[head].data;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < MWQ_ENTRY; i++) begin
        entries[i] <= '0;
      end
    end else begin
      if (push) begin
        entries[tail].address <= sb_mem_addr_i;
        entries[tail].data    <= sb_mem_data_i;
        tail                  <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (sb_mem_v_i && mwq_full_o) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef MWQ_LD_FWD_EN
  logic [MWQ_ENTRY-1:0] match;
  logic [PW-1:0]        sel;

  // Raw address compare on every physical slot; occupancy is applied by the
  // age matcher. Storage updates at the clock edge, so a store being pushed
  // this cycle is invisible to this lookup.
  always_comb begin
    match = '0;
    for (int i = 0; i < MWQ_ENTRY; i++) begin
      match[i] = (entries[i].address == ld_addr_i);
    end
  end

  mwq_age_match #(
    .N  (MWQ_ENTRY),
    .PW (PW)
  ) u_age_match (
    .match (match),
    .head  (head),
    .count (count),
    .hit   (ld_hit_o),
    .sel   (sel)
  );

  assign ld_data_o = ld_hit_o ? entries[sel].data : '0;
`else
  logic unused_ld_addr;

  assign unused_ld_addr = ^ld_addr_i;
  assign ld_hit_o       = 1'b0;
  assign ld_data_o      = '0;
`endif

endmodule

// File: tb/tb_mem_write_queue.sv
// tb_mem_write_queue
// Directed bench for mem_write_queue. Forwarding expectations follow the
// MWQ_LD_FWD_EN build option: with it undefined every lookup must miss.
module tb_mem_write_queue;

  localparam int W = 32;

`ifdef MWQ_LD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic         clk_i;
  logic         reset_n_i;
  logic         sb_mem_v_i;
  logic [W-1:0] sb_mem_addr_i;
  logic [W-1:0] sb_mem_data_i;
  logic         mwq_full_o;
  logic         mwq_empty_o;
  logic         mem_v_o;
  logic [W-1:0] mem_addr_o;
  logic [W-1:0] mem_data_o;
  logic         mem_ready_i;
  logic [W-1:0] ld_addr_i;
  logic         ld_hit_o;
  logic [W-1:0] ld_data_o;
  logic         mwq_overflow_o;

  int checks = 0;
  int errors = 0;

  mem_write_queue dut (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .sb_mem_v_i     (sb_mem_v_i),
    .sb_mem_addr_i  (sb_mem_addr_i),
    .sb_mem_data_i  (sb_mem_data_i),
    .mwq_full_o     (mwq_full_o),
    .mwq_empty_o    (mwq_empty_o),
    .mem_v_o        (mem_v_o),
    .mem_addr_o     (mem_addr_o),
    .mem_data_o     (mem_data_o),
    .mem_ready_i    (mem_ready_i),
    .ld_addr_i      (ld_addr_i),
    .ld_hit_o       (ld_hit_o),
    .ld_data_o      (ld_data_o),
    .mwq_overflow_o (mwq_overflow_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [W-1:0] addr,
                               input logic [W-1:0] data, input logic ready,
                               input logic [W-1:0] ld);
    sb_mem_v_i    = v;
    sb_mem_addr_i = addr;
    sb_mem_data_i = data;
    mem_ready_i   = ready;
    ld_addr_i     = ld;
  endtask

  task automatic stepCycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_full"},  64'(mwq_full_o),     64'd0);
    checkOutput({tag, "_empty"}, 64'(mwq_empty_o),    64'd1);
    checkOutput({tag, "_mem_v"}, 64'(mem_v_o),        64'd0);
    checkOutput({tag, "_addr"},  64'(mem_addr_o),     64'd0);
    checkOutput({tag, "_data"},  64'(mem_data_o),     64'd0);
    checkOutput({tag, "_hit"},   64'(ld_hit_o),       64'd0);
    checkOutput({tag, "_ldata"}, 64'(ld_data_o),      64'd0);
    checkOutput({tag, "_ovf"},   64'(mwq_overflow_o), 64'd0);
  endtask

  initial begin
    reset_n_i = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0, '0);
    stepCycle();
    stepCycle();
    checkResetOutputs("reset");
    reset_n_i = 1'b1;
    stepCycle();

    // Test 1: single store, one-cycle latency, drained immediately.
    $display("[TB] test 1: single store");
    applyStimulus(1'b1, 32'h0010, 32'hBEEF, 1'b1, '0);
    #1;
    checkOutput("t1_pre_mem_v", 64'(mem_v_o), 64'd0);
    stepCycle();
    checkOutput("t1_mem_v", 64'(mem_v_o),    64'd1);
    checkOutput("t1_addr",  64'(mem_addr_o), 64'h0010);
    checkOutput("t1_data",  64'(mem_data_o), 64'hBEEF);
    applyStimulus(1'b0, '0, '0, 1'b1, '0);
    stepCycle();
    checkOutput("t1_empty", 64'(mwq_empty_o), 64'd1);
    checkOutput("t1_mem_v_off", 64'(mem_v_o), 64'd0);

    // Test 2: fill with memory stalled, then overflow.
    $display("[TB] test 2: fill and overflow");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'h0100 + W'(i), 32'hA000 + W'(i), 1'b0, '0);
      stepCycle();
      checkOutput("t2_head_stable", 64'(mem_addr_o), 64'h0100);
    end
    checkOutput("t2_full",     64'(mwq_full_o),     64'd1);
    checkOutput("t2_head_dat", 64'(mem_data_o),     64'hA000);
    checkOutput("t2_no_ovf",   64'(mwq_overflow_o), 64'd0);
    applyStimulus(1'b1, 32'h01FF, 32'hFFFF, 1'b0, '0);
    stepCycle();
    checkOutput("t2_ovf",       64'(mwq_overflow_o), 64'd1);
    checkOutput("t2_full_hold", 64'(mwq_full_o),     64'd1);
    checkOutput("t2_head_keep", 64'(mem_addr_o),     64'h0100);

    // Test 3: full with push and ready together: pop wins, push rejected.
    $display("[TB] test 3: full push with pop");
    applyStimulus(1'b1, 32'h01FE, 32'hEEEE, 1'b1, '0);
    stepCycle();
    checkOutput("t3_not_full", 64'(mwq_full_o), 64'd0);
    checkOutput("t3_head1",    64'(mem_addr_o), 64'h0101);
    applyStimulus(1'b0, '0, '0, 1'b1, '0);
    stepCycle();
    checkOutput("t3_head2", 64'(mem_addr_o), 64'h0102);
    stepCycle();
    checkOutput("t3_head3", 64'(mem_addr_o), 64'h0103);
    checkOutput("t3_data3", 64'(mem_data_o), 64'hA003);
    stepCycle();
    checkOutput("t3_empty",    64'(mwq_empty_o),    64'd1);
    checkOutput("t3_ovf_stay", 64'(mwq_overflow_o), 64'd1);

    // Test 4: streaming push/pop to move the pointers, then forwarding
    // across the wrap point.
    $display("[TB] test 4: wrap and forwarding");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 32'h0300 + W'(i), 32'h5000 + W'(i), 1'b1, '0);
      stepCycle();
      checkOutput("t4_stream", 64'(mem_addr_o), 64'h0300 + 64'(i));
    end
    applyStimulus(1'b0, '0, '0, 1'b1, '0);
    stepCycle();
    checkOutput("t4_drained", 64'(mwq_empty_o), 64'd1);
    applyStimulus(1'b1, 32'h0020, 32'h1111, 1'b0, '0);
    stepCycle();
    applyStimulus(1'b1, 32'h0030, 32'h3333, 1'b0, '0);
    stepCycle();
    applyStimulus(1'b1, 32'h0020, 32'h2222, 1'b0, '0);
    stepCycle();
    applyStimulus(1'b0, '0, '0, 1'b0, 32'h0020);
    #1;
    checkOutput("t4_hit20",  64'(ld_hit_o),  64'(FWD));
    checkOutput("t4_data20", 64'(ld_data_o), FWD ? 64'h2222 : 64'h0);
    ld_addr_i = 32'h0030;
    #1;
    checkOutput("t4_hit30",  64'(ld_hit_o),  64'(FWD));
    checkOutput("t4_data30", 64'(ld_data_o), FWD ? 64'h3333 : 64'h0);
    ld_addr_i = 32'h0040;
    #1;
    checkOutput("t4_miss40", 64'(ld_hit_o), 64'd0);
    applyStimulus(1'b1, 32'h0040, 32'h4444, 1'b0, 32'h0040);
    #1;
    checkOutput("t4_same_cycle", 64'(ld_hit_o), 64'd0);
    stepCycle();
    applyStimulus(1'b0, '0, '0, 1'b0, 32'h0040);
    #1;
    checkOutput("t4_hit40",  64'(ld_hit_o),  64'(FWD));
    checkOutput("t4_data40", 64'(ld_data_o), FWD ? 64'h4444 : 64'h0);
    checkOutput("t4_full",   64'(mwq_full_o), 64'd1);
    applyStimulus(1'b0, '0, '0, 1'b1, 32'h0020);
    stepCycle();
    checkOutput("t4_head30",   64'(mem_addr_o), 64'h0030);
    checkOutput("t4_hit20b",   64'(ld_hit_o),   64'(FWD));
    checkOutput("t4_data20b",  64'(ld_data_o),  FWD ? 64'h2222 : 64'h0);

    // Test 5: asynchronous reset mid-cycle with three stores queued.
    $display("[TB] test 5: async reset");
    applyStimulus(1'b0, '0, '0, 1'b0, 32'h0020);
    #2;
    reset_n_i = 1'b0;
    #1;
    checkResetOutputs("t5_async");
    stepCycle();
    reset_n_i = 1'b1;
    stepCycle();
    checkOutput("t5_still_empty", 64'(mwq_empty_o), 64'd1);
    checkOutput("t5_no_hit",      64'(ld_hit_o),    64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
